alu_issuer: RTL and testbench

Command-driven controller for the 4-bit combinational ALU. It owns a small register file and accepts register-addressed commands over a valid/ready interface. It drives the ALU's opcode and operand inputs, captures the result and flags, and writes the result back. Each result is returned on a valid/ready response channel. It sits between the instruction/test front end and the ALU, and is the only block that drives the ALU's S/A/B inputs.

---
 rtl/alu_issuer.sv | 173 +++++++++++++++++
 tb/tb_alu_issuer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issuer.sv
// Register-file command issuer for the 4-bit combinational ALU: accepts load/ALU commands,
// drives the ALU for one cycle, writes back and returns a response. Optional macro: ALU_ISSUER_STICKY_C_EN.
module alu_issuer #(
    parameter int NREG = 4,
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_ld,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic [3:0]    cmd_imm,
    output logic [2:0]    alu_s,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    input  logic [3:0]    alu_f,
    input  logic          alu_z,
    input  logic          alu_c,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [3:0]    rsp_data,
    output logic          rsp_z,
    output logic          rsp_c,
    output logic          sticky_c
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    rf_val [NREG];
    logic [AW-1:0] rd_reg;
    logic [2:0]    alu_s_reg;
    logic [3:0]    alu_a_reg, alu_b_reg;
    logic [3:0]    rsp_data_reg;
    logic          rsp_z_reg, rsp_c_reg;

    logic          accept, ld_accept, op_accept;
    logic [3:0]    rd_a, rd_b;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;

    assign accept    = cmd_valid && cmd_ready;
    assign ld_accept = accept && cmd_ld;
    assign op_accept = accept && !cmd_ld;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (ld_accept)      state_next = RESP;
                else if (op_accept) state_next = ISSUE;
            end
            ISSUE:   state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_reg)
            IDLE:    cmd_ready = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand reads; indices beyond the file read as zero
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (32'(cmd_ra) < NREG) rd_a = rf_val[cmd_ra];
        if (32'(cmd_rb) < NREG) rd_b = rf_val[cmd_rb];
    end

    // Single write port: ALU writeback in ISSUE, immediate on load accept
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cmd_rd;
        wr_data = cmd_imm;
        if (state_reg == ISSUE) begin
            wr_en   = 1'b1;
            wr_addr = rd_reg;
            wr_data = alu_f;
        end else if (ld_accept) begin
            wr_en = 1'b1;
        end
    end

    // One flop group per entry so reset can clear the whole file; out-of-range writes match nothing
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_rf
            logic [3:0] q_reg;
            always_ff @(posedge clk) begin
                if (rst)                                  q_reg <= '0;
                else if (wr_en && (32'(wr_addr) == gi))   q_reg <= wr_data;
            end
            assign rf_val[gi] = q_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_reg       <= '0;
            alu_s_reg    <= '0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            rsp_data_reg <= '0;
            rsp_z_reg    <= 1'b0;
            rsp_c_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ld_accept) begin
                        rsp_data_reg <= cmd_imm;
                        rsp_z_reg    <= (cmd_imm == 4'd0);
                        rsp_c_reg    <= 1'b0;
                    end else if (op_accept) begin
                        alu_s_reg <= cmd_op;
                        alu_a_reg <= rd_a;
                        alu_b_reg <= rd_b;
                        rd_reg    <= cmd_rd;
                    end
                end
                ISSUE: begin
                    rsp_data_reg <= alu_f;
                    rsp_z_reg    <= alu_z;
                    rsp_c_reg    <= alu_c;
                    alu_s_reg    <= '0;
                    alu_a_reg    <= '0;
                    alu_b_reg    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign alu_s    = alu_s_reg;
    assign alu_a    = alu_a_reg;
    assign alu_b    = alu_b_reg;
    assign rsp_data = rsp_data_reg;
    assign rsp_z    = rsp_z_reg;
    assign rsp_c    = rsp_c_reg;

`ifdef ALU_ISSUER_STICKY_C_EN
    logic sticky_c_reg;
    // Set by any carrying ALU capture; cleared only by "load r0 <- 0"
    always_ff @(posedge clk) begin
        if (rst)                                                  sticky_c_reg <= 1'b0;
        else if (state_reg == ISSUE && alu_c)                     sticky_c_reg <= 1'b1;
        else if (ld_accept && cmd_imm == 4'd0 && cmd_rd == '0)    sticky_c_reg <= 1'b0;
    end
    assign sticky_c = sticky_c_reg;
`else
    assign sticky_c = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issuer.sv
// Self-checking bench for alu_issuer: reference ALU stub, cycle-level response model and
// directed vectors with hand-computed results. Honours ALU_ISSUER_STICKY_C_EN when defined.
module tb_alu_issuer;

    localparam int NREG = 4;
    localparam int AW   = 2;
`ifdef ALU_ISSUER_STICKY_C_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_ld = 1'b0;
    logic [2:0]    cmd_op = '0;
    logic [AW-1:0] cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
    logic [3:0]    cmd_imm = '0;
    logic [2:0]    alu_s;
    logic [3:0]    alu_a, alu_b, alu_f;
    logic          alu_z, alu_c;
    logic          rsp_valid, rsp_ready = 1'b1;
    logic [3:0]    rsp_data;
    logic          rsp_z, rsp_c, sticky_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_issuer #(.NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
        .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
        .alu_f(alu_f), .alu_z(alu_z), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_c(rsp_c), .sticky_c(sticky_c)
    );

    // ALU behaviour: add carry out, sub not-borrow, shl A[3], shr A[0]
    function automatic void spec_alu(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                                     output logic [3:0] f, output logic c);
        logic [4:0] w;
        f = '0;
        c = 1'b0;
        w = '0;
        case (s)
            3'd1: begin w = {1'b0, a} + {1'b0, b}; f = w[3:0]; c = w[4]; end
            3'd2: begin f = a - b; c = (a >= b); end
            3'd3: f = a | b;
            3'd4: f = a & b;
            3'd5: f = a ^ b;
            3'd6: begin f = {a[2:0], 1'b0}; c = a[3]; end
            3'd7: begin f = {1'b0, a[3:1]}; c = a[0]; end
            default: ;
        endcase
    endfunction

    always_comb begin
        alu_f = '0;
        alu_c = 1'b0;
        spec_alu(alu_s, alu_a, alu_b, alu_f, alu_c);
        alu_z = (alu_f == 4'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one command in flight; response becomes valid a fixed number of edges after accept
    logic [3:0] m_rf [NREG];
    bit         m_busy;
    int         m_rem;
    logic [3:0] m_data, p_data;
    bit         m_z, m_c, p_z, p_c, p_alu, m_sticky;
    logic [2:0] m_s;
    logic [3:0] m_a, m_b;

    task automatic publish();
        m_data = p_data;
        m_z    = p_z;
        m_c    = p_c;
        if (p_alu && p_c && STICKY_EN) m_sticky = 1'b1;
    endtask

    always @(negedge clk) begin
        bit         acc;
        logic [3:0] fa, fb, ff;
        logic       fc;
        if (!rst) begin
            check("cmd_ready", cmd_ready, !m_busy);
            check("rsp_valid", rsp_valid, m_busy && m_rem == 0);
            check("rsp_data",  rsp_data,  m_data);
            check("rsp_z",     rsp_z,     m_z);
            check("rsp_c",     rsp_c,     m_c);
            check("alu_s",     alu_s,     m_s);
            check("alu_a",     alu_a,     m_a);
            check("alu_b",     alu_b,     m_b);
            check("sticky_c",  sticky_c,  m_sticky);
        end
        // Predict the state after the coming rising edge
        if (rst) begin
            for (int i = 0; i < NREG; i++) m_rf[i] = '0;
            m_busy = 0; m_rem = 0; m_data = '0; m_z = 0; m_c = 0; m_sticky = 0;
            m_s = '0; m_a = '0; m_b = '0; p_alu = 0;
        end else begin
            acc = !m_busy && cmd_valid;
            if (m_busy) begin
                if (m_rem == 0) begin
                    if (rsp_ready) m_busy = 0;
                end else begin
                    m_rem--;
                    if (m_rem == 0) publish();
                end
            end
            m_s = '0; m_a = '0; m_b = '0;
            if (acc) begin
                m_busy = 1;
                if (cmd_ld) begin
                    m_rf[cmd_rd] = cmd_imm;
                    p_data = cmd_imm; p_z = (cmd_imm == 0); p_c = 0; p_alu = 0;
                    m_rem = 0;
                    publish();
                    if (STICKY_EN && cmd_imm == 0 && cmd_rd == 0) m_sticky = 0;
                end else begin
                    fa = m_rf[cmd_ra];
                    fb = m_rf[cmd_rb];
                    spec_alu(cmd_op, fa, fb, ff, fc);
                    m_rf[cmd_rd] = ff;
                    p_data = ff; p_z = (ff == 0); p_c = fc; p_alu = 1;
                    m_rem = 1;
                    m_s = cmd_op; m_a = fa; m_b = fb;
                end
            end
        end
    end

    // Issue one command with rsp_ready high; check accept wait, latency and literal result
    task automatic do_cmd(input bit ld, input logic [2:0] op, input logic [AW-1:0] rd,
                          input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic [3:0] imm,
                          input logic [3:0] ed, input bit ez, input bit ec);
        int n;
        int lat;
        cmd_ld = ld; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        check("accept_wait", n, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("latency", lat, ld ? 1 : 2);
        check("lit_data", rsp_data, ed);
        check("lit_z", rsp_z, ez);
        check("lit_c", rsp_c, ec);
        $display("txn ld=%0d op=%0d rd=%0d ra=%0d rb=%0d imm=%0h -> data=%0h z=%0d c=%0d lat=%0d",
                 ld, op, rd, ra, rb, imm, rsp_data, rsp_z, rsp_c, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_sticky", sticky_c, 0);

        // Subtract both ways
        do_cmd(1, 3'd0, 2'd0, 2'd0, 2'd0, 4'h5, 4'h5, 0, 0);
        do_cmd(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'h3, 4'h3, 0, 0);
        do_cmd(0, 3'd2, 2'd2, 2'd0, 2'd1, 4'h0, 4'h2, 0, 1);
        do_cmd(0, 3'd2, 2'd3, 2'd1, 2'd0, 4'h0, 4'hE, 0, 0);
        // rd == ra uses the old value; then shift the result
        do_cmd(1, 3'd0, 2'd0, 2'd0, 2'd0, 4'h9, 4'h9, 0, 0);
        do_cmd(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'h8, 4'h8, 0, 0);
        do_cmd(0, 3'd1, 2'd0, 2'd0, 2'd1, 4'h0, 4'h1, 0, 1);
        do_cmd(0, 3'd6, 2'd2, 2'd0, 2'd0, 4'h0, 4'h2, 0, 0);
        do_cmd(0, 3'd5, 2'd3, 2'd1, 2'd1, 4'h0, 4'h0, 1, 0);
        do_cmd(0, 3'd0, 2'd2, 2'd0, 2'd1, 4'h0, 4'h0, 1, 0);
        do_cmd(1, 3'd0, 2'd0, 2'd0, 2'd0, 4'h3, 4'h3, 0, 0);
        do_cmd(0, 3'd7, 2'd1, 2'd0, 2'd0, 4'h0, 4'h1, 0, 1);
        do_cmd(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'h6, 4'h6, 0, 0);
        do_cmd(0, 3'd4, 2'd2, 2'd0, 2'd1, 4'h0, 4'h2, 0, 0);

        // Sticky carry
        do_cmd(1, 3'd0, 2'd0, 2'd0, 2'd0, 4'hF, 4'hF, 0, 0);
        do_cmd(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'h1, 4'h1, 0, 0);
        do_cmd(0, 3'd1, 2'd2, 2'd0, 2'd1, 4'h0, 4'h0, 1, 1);
        do_cmd(1, 3'd0, 2'd0, 2'd0, 2'd0, 4'h1, 4'h1, 0, 0);
        do_cmd(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'h2, 4'h2, 0, 0);
        do_cmd(0, 3'd3, 2'd3, 2'd0, 2'd1, 4'h0, 4'h3, 0, 0);
        check("lit_sticky_held", sticky_c, STICKY_EN);
        do_cmd(1, 3'd0, 2'd0, 2'd0, 2'd0, 4'h0, 4'h0, 1, 0);
        check("lit_sticky_clr", sticky_c, 0);

        // Response back-pressure with ignored command pulses
        rsp_ready = 1'b0;
        cmd_ld = 1'b1; cmd_rd = 2'd2; cmd_imm = 4'h7; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_rd = 2'd3; cmd_imm = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", rsp_valid, 1);
            check("stall_data", rsp_data, 4'h7);
            check("stall_ready", cmd_ready, 0);
            $display("txn stall cycle %0d data=%0h", i, rsp_data);
            cmd_valid = (i % 2 == 0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("release_ready", cmd_ready, 1);
        check("release_valid", rsp_valid, 0);
        do_cmd(0, 3'd1, 2'd0, 2'd2, 2'd3, 4'h0, 4'hA, 0, 0);

        // Reset in the middle of an ALU command
        do_cmd(1, 3'd0, 2'd0, 2'd0, 2'd0, 4'h5, 4'h5, 0, 0);
        do_cmd(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'h3, 4'h3, 0, 0);
        cmd_ld = 1'b0; cmd_op = 3'd1; cmd_rd = 2'd2; cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("issue_s", alu_s, 3'd1);
        check("issue_a", alu_a, 4'h5);
        check("issue_b", alu_b, 4'h3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ready", cmd_ready, 1);
        check("midrst_alu_s", alu_s, 0);
        for (int i = 0; i < 4; i++) begin
            check("midrst_no_rsp", rsp_valid, 0);
            @(posedge clk); #1;
        end
        $display("txn reset during ISSUE, no response");
        do_cmd(0, 3'd3, 2'd2, 2'd0, 2'd1, 4'h0, 4'h0, 1, 0);
        do_cmd(0, 3'd1, 2'd3, 2'd2, 2'd3, 4'h0, 4'h0, 1, 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
